neander_mem_arbiter: RTL and testbench
======================================

// Module: neander_mem_arbiter
// PURPOSE
//  Shares the single-port 256x8 RAM (async read, sync write) between two requesters.
//  Port A is the Neander CPU; port B is the external program loader/debugger.
//  One access per cycle, with round-robin fairness bounded by a burst limit.
//  B can lock the RAM for multi-byte loads. Non-granted requesters stall.
// PARAMETERS
//  ADDR_W     8  address width (RAM depth 2**ADDR_W)
//  DATA_W     8  data width
//  MAX_BURST  4  max consecutive grants to one side while the other waits; legal 1..15
// PORTS
//  clk        in   1       system clock, all state on rising edge
//  reset      in   1       asynchronous, active-high reset
//  a_req      in   1       CPU access request; hold with a_we/a_addr/a_wdata stable until a_gnt
//  a_we       in   1       1=write, 0=read
//  a_addr     in   ADDR_W  CPU address
//  a_wdata    in   DATA_W  CPU write data
//  a_gnt      out  1       access performed this cycle (comb. from req + registered state)
//  a_stall    out  1       a_req & ~a_gnt; drives the CPU clock-enable/stall
//  a_rdata    out  DATA_W  registered read data
//  a_rvalid   out  1       one-cycle pulse, cycle after a granted read
//  b_req/b_we/b_addr/b_wdata/b_gnt/b_rdata/b_rvalid  same semantics, loader side
//  b_lock     in   1       with b_req=1, B wins every cycle regardless of fairness
//  ram_addr   out  ADDR_W  RAM address
//  ram_wdata  out  DATA_W  RAM write data
//  ram_we     out  1       RAM write strobe
//  ram_rdata  in   DATA_W  RAM async read data
// BEHAVIOUR
//  State: last (0=A,1=B; reset A), burst_cnt (4b; reset 0); rdata/rvalid regs reset 0.
//  While reset=1: a_gnt=b_gnt=ram_we=0, rvalids=0; in-flight requests dropped (not replayed).
//  Grant (one side max per cycle):
//   - no req: no grant; burst_cnt<=0; last unchanged.
//   - one req: that side granted at once (zero wait).
//   - both, b_lock=1: B.
//   - both, b_lock=0: grant `last` if burst_cnt<MAX_BURST, else the other side.
//  Update on grant: same side as last -> burst_cnt<=sat(burst_cnt+1, MAX_BURST);
//   other side -> last<=side, burst_cnt<=1.
//  RAM mux: granted side drives ram_addr/ram_wdata; ram_we = gnt & we.
//   No grant: ram_addr=a_addr, ram_we=0.
//  Write commits at the edge ending the grant cycle.
//  Read: x_rdata<=ram_rdata and x_rvalid<=1 at that edge; x_rdata holds until next granted read.
//  Same address, consecutive cycles: a read granted the cycle after a write returns the new data.
//  Same-cycle conflicts cannot occur (single grant). Ungranted side keeps request stable; not an error.
//  b_lock with b_req=0: no effect; A granted normally.
//  b_lock dropped mid-burst: fairness resumes from the current last/burst_cnt.
// CONFIGURATION
//  NEANDER_ARB_STATS_EN defined: adds ports
//   stat_clr in 1, stat_a_wait out 16, stat_b_wait out 16.
//   Counters increment on cycles with x_req & ~x_gnt, saturate at 16'hFFFF.
//   Cleared by reset or by stat_clr (clear wins over increment).
//  Undefined: those ports and counters are absent; arbitration unchanged.
// TESTING
//  1. Reset, then A reads 0x10 (RAM=0x5A), B idle -> a_gnt same cycle; next cycle a_rvalid=1, a_rdata=0x5A.
//  2. A and B both request continuously, MAX_BURST=4, after reset -> grants AAAA BBBB AAAA...;
//     a_stall high exactly on B cycles.
//  3. b_lock=1, B writes 0x00..0x0F (data=addr^0xFF) while A requests -> 16 consecutive B grants;
//     A stalls; readback all match.
//  4. B writes 0x20<=0x33 and A reads 0x20 the next cycle -> a_rdata=0x33.
//  5. Reset asserted mid-burst (cycle 2 of B's 4) -> gnt/rvalid drop immediately;
//     after release, A wins first contention.
//  6. STATS_EN: 10 cycles of contention, MAX_BURST=4 -> sum of wait counters = 10;
//     stat_clr zeroes both; 0xFFFF+1 holds.

Source files
------------

// File: rtl/neander_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : neander_mem_arbiter
// Purpose  : Shares a single-port RAM (async read, sync write) between the
//            Neander CPU (port A) and the program loader/debugger (port B).
//            Round-robin with a burst limit; B may lock the RAM.
//            Optional wait-cycle statistics: define NEANDER_ARB_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module neander_mem_arbiter #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              reset,
  // CPU side
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_stall,
  output logic [DATA_W-1:0] a_rdata,
  output logic              a_rvalid,
  // loader side
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  input  logic              b_lock,
  output logic              b_gnt,
  output logic              b_stall,
  output logic [DATA_W-1:0] b_rdata,
  output logic              b_rvalid,
  // RAM side
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
`ifdef NEANDER_ARB_STATS_EN
  input  logic              stat_clr,
  output logic [15:0]       stat_a_wait,
  output logic [15:0]       stat_b_wait,
`endif
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam logic [3:0]  c_max      = 4'(MAX_BURST);
  localparam logic        c_side_a   = 1'b0;
  localparam logic [15:0] c_stat_max = 16'hFFFF;

  logic       r_last;     // side that received the most recent grant
  logic [3:0] r_burst;    // consecutive grants to r_last, saturating
  logic       w_pick_b;
  logic       w_a_gnt;
  logic       w_b_gnt;

  // Choose the winning side from requests, lock and fairness state
  always_comb begin
    w_pick_b = 1'b0;
    if (b_req && !a_req) begin
      w_pick_b = 1'b1;
    end else if (a_req && b_req) begin
      if (b_lock) begin
        w_pick_b = 1'b1;
      end else if (r_burst < c_max) begin
        w_pick_b = r_last;
      end else begin
        w_pick_b = ~r_last;
      end
    end
  end

  // Grants are masked while reset is held so nothing reaches the RAM
  assign w_a_gnt  = ~reset & a_req & ~w_pick_b;
  assign w_b_gnt  = ~reset & b_req &  w_pick_b;
  assign a_gnt    = w_a_gnt;
  assign b_gnt    = w_b_gnt;
  assign a_stall  = a_req & ~w_a_gnt;
  assign b_stall  = b_req & ~w_b_gnt;

  // With no grant the bus idles on the CPU address
  assign ram_addr  = w_b_gnt ? b_addr  : a_addr;
  assign ram_wdata = w_b_gnt ? b_wdata : a_wdata;
  assign ram_we    = (w_a_gnt & a_we) | (w_b_gnt & b_we);

  // Fairness state: extend the current burst or hand ownership over
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last  <= c_side_a;
      r_burst <= 4'd0;
    end else if (w_a_gnt || w_b_gnt) begin
      if (w_b_gnt == r_last) begin
        if (r_burst < c_max) begin
          r_burst <= r_burst + 4'd1;
        end else begin
          r_burst <= c_max;
        end
      end else begin
        r_last  <= w_b_gnt;
        r_burst <= 4'd1;
      end
    end else begin
      r_burst <= 4'd0;
    end
  end

  // CPU read return: capture RAM data at the end of a granted read
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_rdata  <= '0;
      a_rvalid <= 1'b0;
    end else begin
      a_rvalid <= w_a_gnt & ~a_we;
      if (w_a_gnt && !a_we) begin
        a_rdata <= ram_rdata;
      end
    end
  end

  // Loader read return: capture RAM data at the end of a granted read
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      b_rdata  <= '0;
      b_rvalid <= 1'b0;
    end else begin
      b_rvalid <= w_b_gnt & ~b_we;
      if (w_b_gnt && !b_we) begin
        b_rdata <= ram_rdata;
      end
    end
  end

`ifdef NEANDER_ARB_STATS_EN
  logic [15:0] r_a_wait;
  logic [15:0] r_b_wait;

  // Saturating stall-cycle counters; clear takes priority over counting
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a_wait <= 16'd0;
      r_b_wait <= 16'd0;
    end else if (stat_clr) begin
      r_a_wait <= 16'd0;
      r_b_wait <= 16'd0;
    end else begin
      if (a_stall && r_a_wait != c_stat_max) begin
        r_a_wait <= r_a_wait + 16'd1;
      end
      if (b_stall && r_b_wait != c_stat_max) begin
        r_b_wait <= r_b_wait + 16'd1;
      end
    end
  end

  assign stat_a_wait = r_a_wait;
  assign stat_b_wait = r_b_wait;
`endif

endmodule
`default_nettype wire

// File: tb/tb_neander_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_neander_mem_arbiter
// Purpose  : Self-checking bench for neander_mem_arbiter: vector table,
//            directed corner sequences and randomized traffic against a
//            grant-history reference model. Stats checks when
//            NEANDER_ARB_STATS_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_neander_mem_arbiter;

  localparam int MAXB = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       a_req = 0, a_we = 0, b_req = 0, b_we = 0, b_lock = 0;
  logic [7:0] a_addr = 0, a_wdata = 0, b_addr = 0, b_wdata = 0;
  logic       a_gnt, a_stall, a_rvalid, b_gnt, b_stall, b_rvalid, ram_we;
  logic [7:0] a_rdata, b_rdata, ram_addr, ram_wdata, ram_rdata;
`ifdef NEANDER_ARB_STATS_EN
  logic        stat_clr = 1'b0;
  logic [15:0] stat_a_wait, stat_b_wait;
`endif

  neander_mem_arbiter #(.ADDR_W(8), .DATA_W(8), .MAX_BURST(MAXB)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_stall(a_stall), .a_rdata(a_rdata), .a_rvalid(a_rvalid),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_lock(b_lock), .b_gnt(b_gnt), .b_stall(b_stall), .b_rdata(b_rdata),
    .b_rvalid(b_rvalid),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
`ifdef NEANDER_ARB_STATS_EN
    .stat_clr(stat_clr), .stat_a_wait(stat_a_wait), .stat_b_wait(stat_b_wait),
`endif
    .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // Physical RAM seen by the DUT
  logic [7:0] mem [256];
  assign ram_rdata = mem[ram_addr];
  always @(posedge clk) if (ram_we) mem[ram_addr] <= ram_wdata;

  // Reference model state
  logic [7:0] refmem [256];
  int         hist[$];          // grant side per cycle since reset: 0=A, 1=B, -1=none
  logic       e_arv, e_brv;
  logic [7:0] e_ard, e_brd;
  int         e_aw, e_bw;
  int         total = 0, bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected winner from request pattern and grant history
  function automatic int exp_pick(input logic ar, input logic br, input logic bl);
    int last = 0;
    int run  = 0;
    for (int i = hist.size() - 1; i >= 0; i--) begin
      if (hist[i] != -1) begin last = hist[i]; break; end
    end
    for (int i = hist.size() - 1; i >= 0; i--) begin
      if (hist[i] == last) run++; else break;
    end
    if (!ar && !br) return -1;
    if (ar && !br)  return 0;
    if (!ar && br)  return 1;
    if (bl)         return 1;
    return (run < MAXB) ? last : 1 - last;
  endfunction

  task automatic model_reset();
    hist.delete();
    e_arv = 0; e_brv = 0; e_ard = 0; e_brd = 0; e_aw = 0; e_bw = 0;
  endtask

  // One bus cycle: drive, check at negedge, advance model at posedge
  task automatic step(input logic ar, input logic aw, input logic [7:0] aa, input logic [7:0] ad,
                      input logic br, input logic bw, input logic [7:0] ba, input logic [7:0] bd,
                      input logic bl, output int g, output int obs);
    a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad;
    b_req = br; b_we = bw; b_addr = ba; b_wdata = bd; b_lock = bl;
    @(negedge clk);
    g   = exp_pick(ar, br, bl);
    obs = a_gnt ? 0 : (b_gnt ? 1 : -1);
    chk("a_gnt",    a_gnt,    g == 0);
    chk("b_gnt",    b_gnt,    g == 1);
    chk("a_stall",  a_stall,  ar && g != 0);
    chk("b_stall",  b_stall,  br && g != 1);
    chk("ram_we",   ram_we,   (g == 0 && aw) || (g == 1 && bw));
    chk("ram_addr", ram_addr, (g == 1) ? ba : aa);
    if (g == 0 && aw) chk("ram_wdata", ram_wdata, ad);
    if (g == 1 && bw) chk("ram_wdata", ram_wdata, bd);
    chk("a_rvalid", a_rvalid, e_arv);
    chk("a_rdata",  a_rdata,  e_ard);
    chk("b_rvalid", b_rvalid, e_brv);
    chk("b_rdata",  b_rdata,  e_brd);
`ifdef NEANDER_ARB_STATS_EN
    chk("stat_a", stat_a_wait, e_aw);
    chk("stat_b", stat_b_wait, e_bw);
`endif
    @(posedge clk);
    hist.push_back(g);
    e_arv = (g == 0 && !aw);
    e_brv = (g == 1 && !bw);
    if (e_arv) e_ard = refmem[aa];
    if (e_brv) e_brd = refmem[ba];
    if (g == 0 && aw) refmem[aa] = ad;
    if (g == 1 && bw) refmem[ba] = bd;
    if (ar && g != 0 && e_aw < 65535) e_aw++;
    if (br && g != 1 && e_bw < 65535) e_bw++;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_a_gnt", a_gnt, 1'b0);
    chk("rst_b_gnt", b_gnt, 1'b0);
    chk("rst_ram_we", ram_we, 1'b0);
    chk("rst_a_rvalid", a_rvalid, 1'b0);
    chk("rst_b_rvalid", b_rvalid, 1'b0);
    chk("rst_a_rdata", a_rdata, 8'h00);
    @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
  endtask

  typedef struct {
    logic ar; logic aw; logic [7:0] aa; logic [7:0] ad;
    logic br; logic bw; logic [7:0] ba; logic [7:0] bd;
    logic bl; int eg;
  } vec_t;

  vec_t tbl[9];

  initial begin
    int g, obs;
    logic pa, pb, paw, pbw;
    logic [7:0] paa, pad, pba, pbd;

    for (int i = 0; i < 256; i++) begin
      mem[i]    = 8'(i) ^ 8'h4A;
      refmem[i] = 8'(i) ^ 8'h4A;
    end
    model_reset();

    //          ar aw aa     ad     br bw ba     bd     bl eg
    tbl[0] = '{1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00, 0,  0};  // lone A read, mem=5A
    tbl[1] = '{0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, -1};  // idle
    tbl[2] = '{0, 0, 8'h00, 8'h00, 1, 1, 8'h20, 8'h33, 0,  1};  // lone B write
    tbl[3] = '{1, 0, 8'h20, 8'h00, 0, 0, 8'h00, 8'h00, 0,  0};  // A reads back new data
    tbl[4] = '{1, 0, 8'h30, 8'h00, 1, 0, 8'h31, 8'h00, 0,  0};  // contention, A owns burst
    tbl[5] = '{1, 0, 8'h30, 8'h00, 1, 0, 8'h31, 8'h00, 1,  1};  // lock overrides
    tbl[6] = '{1, 0, 8'h30, 8'h00, 1, 0, 8'h31, 8'h00, 0,  1};  // B keeps burst after lock drop
    tbl[7] = '{1, 1, 8'h32, 8'hC3, 0, 0, 8'h00, 8'h00, 1,  0};  // lock without req ignored
    tbl[8] = '{1, 0, 8'h32, 8'h00, 1, 0, 8'h31, 8'h00, 0,  0};  // A readback, A owns

    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Vector table
    for (int i = 0; i < 9; i++) begin
      step(tbl[i].ar, tbl[i].aw, tbl[i].aa, tbl[i].ad, tbl[i].br, tbl[i].bw,
           tbl[i].ba, tbl[i].bd, tbl[i].bl, g, obs);
      chk("tbl_gnt", obs, tbl[i].eg);
      if (i == 0) begin
        chk("tbl_rvalid", a_rvalid, 1'b1);
        chk("tbl_rd_5A", a_rdata, 8'h5A);
      end
      if (i == 3) chk("tbl_rd_33", a_rdata, 8'h33);
    end

    // Round robin with burst limit from reset
    do_reset();
    for (int i = 0; i < 16; i++) begin
      step(1, 0, 8'h01, 0, 1, 0, 8'h02, 0, 0, g, obs);
      chk("rr_seq", obs, (i / 4) % 2);
    end

    // Locked multi-byte load then locked readback
    for (int i = 0; i < 16; i++) begin
      step(1, 0, 8'h40, 0, 1, 1, 8'(i), 8'(i) ^ 8'hFF, 1, g, obs);
      chk("lock_wr_gnt", obs, 1);
    end
    for (int i = 0; i < 16; i++) begin
      step(1, 0, 8'h40, 0, 1, 0, 8'(i), 0, 1, g, obs);
      chk("lock_rd", b_rdata, 8'(i) ^ 8'hFF);
    end

    // Reset during the second beat of a B burst
    do_reset();
    for (int i = 0; i < 5; i++) step(1, 0, 8'h05, 0, 1, 0, 8'h06, 0, 0, g, obs);
    @(negedge clk);
    chk("mid_b_gnt", b_gnt, 1'b1);
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_b_gnt", b_gnt, 1'b0);
    chk("mid_rst_a_gnt", a_gnt, 1'b0);
    chk("mid_rst_b_rvalid", b_rvalid, 1'b0);
    @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
    step(1, 0, 8'h05, 0, 1, 0, 8'h06, 0, 0, g, obs);
    chk("post_rst_winner", obs, 0);

    // Randomized traffic; requesters hold until granted
    pa = 0; pb = 0; paw = 0; pbw = 0; paa = 0; pad = 0; pba = 0; pbd = 0;
    for (int i = 0; i < 400; i++) begin
      if (!pa) begin
        pa = ($urandom_range(0, 9) < 7); paw = $urandom_range(0, 1) == 1;
        paa = 8'($urandom_range(0, 31)); pad = 8'($urandom);
      end
      if (!pb) begin
        pb = ($urandom_range(0, 9) < 6); pbw = $urandom_range(0, 1) == 1;
        pba = 8'($urandom_range(0, 31)); pbd = 8'($urandom);
      end
      step(pa, paw, paa, pad, pb, pbw, pba, pbd, $urandom_range(0, 4) == 0, g, obs);
      if (g == 0) pa = 0;
      if (g == 1) pb = 0;
    end

`ifdef NEANDER_ARB_STATS_EN
    do_reset();
    for (int i = 0; i < 10; i++) step(1, 0, 8'h01, 0, 1, 0, 8'h02, 0, 0, g, obs);
    @(negedge clk);
    chk("stat_sum10", 32'(stat_a_wait) + 32'(stat_b_wait), 10);
    stat_clr = 1'b1;
    a_req = 1; b_req = 1;
    @(posedge clk);
    #1 stat_clr = 1'b0;
    chk("stat_clr_a", stat_a_wait, 0);
    chk("stat_clr_b", stat_b_wait, 0);
    b_lock = 1'b1;
    repeat (65540) @(posedge clk);
    #1;
    chk("stat_sat_a", stat_a_wait, 16'hFFFF);
    chk("stat_sat_b", stat_b_wait, 16'h0000);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
